instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter MEM_BYTES, default 128, SHALL be the instruction-memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word driven on bubbles.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-006 imem_addr  output  32  byte address to instruction memory, equal to pc.
REQ-007 imem_data  input  32  instruction word returned combinationally, same cycle, for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 redirect_pc  input  32  target address qualifying redirect_valid.
REQ-010 id_ready  input  1  decode stage accepts the IF/ID register this cycle.
REQ-011 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 if_instr  output  32  registered instruction.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 if_pc_plus4  output  32  if_pc + 4.
REQ-015 fetch_fault  output  1  fetch unit halted on misaligned or out-of-range address.
REQ-016 fetch_count  output  32  number of instructions handed to decode.

Function
REQ-017 States SHALL be BOOT, RUN, FAULT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-018 advance SHALL equal (~if_valid | id_ready), evaluated combinationally.
REQ-019 In RUN with advance=1 and redirect_valid=0: pc SHALL become pc+4; IF/ID SHALL load {valid=1, imem_data, pc, pc+4}.
REQ-020 In RUN with advance=0 and redirect_valid=0: pc and IF/ID SHALL hold.
REQ-021 redirect_valid=1 SHALL override stall: pc <= redirect_pc; IF/ID SHALL load bubble {valid=0, NOP_INSTR}; the wrong-path word SHALL be discarded.
REQ-022 First post-redirect instruction SHALL appear on if_instr exactly 1 cycle after the redirect cycle (if not stalled).
REQ-023 A redirect with redirect_pc[1:0]!=0 or redirect_pc>MEM_BYTES-4 SHALL enter FAULT next cycle.
REQ-024 Sequential increment from pc=MEM_BYTES-4 SHALL deliver that last word and then enter FAULT; no wrap to 0.
REQ-025 In FAULT: fetch_fault=1, if_valid=0, pc frozen, redirect ignored, until reset.
REQ-026 In BOOT: if_valid=0, pc=RESET_PC, no fetch_count increment.
REQ-027 fetch_count SHALL increment by 1 on each cycle with if_valid=1 and id_ready=1; wraps modulo 2^32.
REQ-028 All pc arithmetic SHALL be 32-bit unsigned, carry discarded.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state=BOOT, pc=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=0, fetch_fault=0, fetch_count=0.
REQ-030 Reset mid-stall or mid-redirect SHALL take priority over all other inputs in that cycle.
REQ-031 A RESET_PC that is misaligned or out of range SHALL cause FAULT on the BOOT->RUN transition.

Structure
REQ-032 State encoding, NOP_INSTR default and instruction width SHALL live in the shared core package.
REQ-033 The IF/ID register SHALL be a sub-module named if_id_reg (load, bubble, hold controls).
REQ-034 The PC register, next-PC mux, range check and FSM SHALL reside in instruction_fetch.

Verification
REQ-035 Reset then 4 cycles id_ready=1 -> if_pc 0,4,8 on cycles 2-4; if_valid=0 in BOOT; fetch_count=2 after cycle 4.
REQ-036 id_ready=0 for 3 cycles while if_pc=8 -> if_pc, if_instr, imem_addr=12 hold; resume to if_pc=12 next.
REQ-037 redirect_valid=1, redirect_pc=0x40 while id_ready=0 -> next cycle if_valid=0, imem_addr=0x40; following cycle if_pc=0x40.
REQ-038 redirect_pc=0x42 -> fetch_fault=1 next cycle; later redirect to 0x0 ignored; rst_n=0 clears it.
REQ-039 Sequential run to pc=124 (MEM_BYTES=128) -> if_pc=124 delivered, then fetch_fault=1, if_valid=0.
REQ-040 rst_n=0 for one edge during stall with if_valid=1 -> all outputs equal REQ-029 values next cycle.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the fetch stage: widths, bubble encoding, FSM states, IF/ID record.
// Pure declarations; no timing of its own.
// Imported by the fetch interface, the IF/ID register and the fetch top.
package instruction_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  // addi x0,x0,0 -- the canonical no-op placed in the IF/ID slot on bubbles
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic               vld;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
  } ifid_t;

  // 32-bit wrap-around increment; carry out is deliberately dropped
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of fetch-stage signals: instruction-memory port, redirect input, IF/ID outputs.
// No storage; latency is whatever the connected modules impose.
// Decode backpressure arrives on id_ready; the fetch unit is the master side.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               id_ready;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [XLEN-1:0]    if_pc;
  logic [XLEN-1:0]    if_pc_plus4;
  logic               fetch_fault;
  logic [31:0]        fetch_count;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output fetch_fault,
    output fetch_count
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  fetch_fault,
    input  fetch_count
  );

endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register with load, bubble and hold controls.
// One cycle: controls sampled at the rising edge take effect on the outputs right after.
// Neither control asserted means hold, which is how a decode stall is absorbed.
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  bubble_i,
  input  ifid_t ifid_i,
  output ifid_t ifid_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  // Bubble wins over load: a squashed slot must never carry the wrong-path word.
  // A bubble keeps the old pc fields; only valid and the instruction word change.
  always_comb begin
    ifid_d = ifid_q;
    if (bubble_i) begin
      ifid_d.vld   = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (load_i) begin
      ifid_d = ifid_i;
    end
  end

  // Register with synchronous active-low reset to an empty NOP slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q <= '{vld: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, next-PC selection, address range check and BOOT/RUN/FAULT FSM.
// Memory read is combinational; an instruction reaches IF/ID one cycle after its address is driven.
// A full IF/ID slot with id_ready low stalls the PC; a redirect overrides the stall.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000,
  parameter int unsigned        MEM_BYTES = 128,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  instruction_fetch_if.master fe
);

  localparam logic [XLEN-1:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  // Legal fetch address: word aligned and inside the instruction memory
  function automatic logic addr_ok(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     count_q;
  logic [31:0]     count_d;

  logic  load;
  logic  bubble;
  logic  advance;
  logic  if_valid;
  ifid_t ifid_in;
  ifid_t ifid_out;

  // The slot can take a new word when it is empty or decode is draining it
  assign if_valid = ifid_out.vld & (state_q != S_FAULT);
  assign advance  = ~if_valid | fe.id_ready;

  // Next state, next PC and IF/ID controls.
  // BOOT fetches like RUN but ignores redirects, since nothing downstream can have issued one yet.
  // A bad PC is only acted on when the slot advances, so the last legal word is still handed over.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      S_BOOT, S_RUN: begin
        if ((state_q == S_RUN) && fe.redirect_valid) begin
          bubble  = 1'b1;
          pc_d    = fe.redirect_pc;
          state_d = addr_ok(fe.redirect_pc) ? S_RUN : S_FAULT;
        end else if (advance) begin
          if (addr_ok(pc_q)) begin
            load    = 1'b1;
            pc_d    = pc_inc(pc_q);
            state_d = S_RUN;
          end else begin
            bubble  = 1'b1;
            state_d = S_FAULT;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Handed-over instruction counter, free-running modulo 2^32
  assign count_d = count_q + {31'd0, (if_valid & fe.id_ready)};

  // PC and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign ifid_in = '{vld: 1'b1, instr: fe.imem_data, pc: pc_q, pc_plus4: pc_inc(pc_q)};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .bubble_i (bubble),
    .ifid_i   (ifid_in),
    .ifid_o   (ifid_out)
  );

  assign fe.imem_addr   = pc_q;
  assign fe.if_valid    = if_valid;
  assign fe.if_instr    = ifid_out.instr;
  assign fe.if_pc       = ifid_out.pc;
  assign fe.if_pc_plus4 = ifid_out.pc_plus4;
  assign fe.fetch_fault = (state_q == S_FAULT);
  assign fe.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a randomized scoreboard run.
// Inputs are driven and outputs sampled on the falling clock edge.
// A second instance with a misaligned reset PC exercises the boot-time fault.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  instruction_fetch_if bus ();
  instruction_fetch_if bus2 ();

  assign bus.imem_data = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

  assign bus2.imem_data      = 32'h0;
  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = 32'h0;
  assign bus2.id_ready       = 1'b1;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (128),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fe    (bus.master)
  );

  instruction_fetch #(
    .RESET_PC  (32'h0000_0002),
    .MEM_BYTES (128),
    .NOP_INSTR (NOP)
  ) dut_bad (
    .clk   (clk),
    .rst_n (rst_n),
    .fe    (bus2.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle, ending just after the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".if_valid"},    {31'd0, bus.if_valid},    32'd0);
    check({tag, ".if_instr"},    bus.if_instr,             NOP);
    check({tag, ".if_pc"},       bus.if_pc,                32'd0);
    check({tag, ".if_pc_plus4"}, bus.if_pc_plus4,          32'd0);
    check({tag, ".fetch_fault"}, {31'd0, bus.fetch_fault}, 32'd0);
    check({tag, ".fetch_count"}, bus.fetch_count,          32'd0);
    check({tag, ".imem_addr"},   bus.imem_addr,            32'd0);
  endtask

  // Reference model state for the random phase
  logic [31:0] exp_addr;
  logic [31:0] count_m;
  int          bubble_left;
  logic        rdy;
  logic        redir;
  logic [31:0] tgt;
  logic        seen;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    rst_n              = 1'b0;
    @(negedge clk);
    tick();

    // Reset state, then boot and sequential fetch
    check_reset_values("reset");
    rst_n = 1'b1;
    check("boot.if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("boot.imem_addr", bus.imem_addr, 32'd0);
    check("bad_rst.boot_fault", {31'd0, bus2.fetch_fault}, 32'd0);
    tick();
    check("c2.if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("c2.if_pc", bus.if_pc, 32'd0);
    check("c2.if_instr", bus.if_instr, mem[0]);
    check("c2.if_pc_plus4", bus.if_pc_plus4, 32'd4);
    check("bad_rst.fault", {31'd0, bus2.fetch_fault}, 32'd1);
    check("bad_rst.if_valid", {31'd0, bus2.if_valid}, 32'd0);
    tick();
    check("c3.if_pc", bus.if_pc, 32'd4);
    tick();
    check("c4.if_pc", bus.if_pc, 32'd8);
    check("c4.fetch_count", bus.fetch_count, 32'd2);

    // Decode stall holds the slot and the PC
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.if_pc", bus.if_pc, 32'd8);
      check("stall.if_instr", bus.if_instr, mem[2]);
      check("stall.imem_addr", bus.imem_addr, 32'd12);
      check("stall.fetch_count", bus.fetch_count, 32'd2);
    end
    bus.id_ready = 1'b1;
    tick();
    check("resume.if_pc", bus.if_pc, 32'd12);
    check("resume.fetch_count", bus.fetch_count, 32'd3);

    // Redirect overrides a stall and squashes the slot
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    check("redir.if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("redir.if_instr", bus.if_instr, NOP);
    check("redir.imem_addr", bus.imem_addr, 32'h40);
    check("redir.fetch_count", bus.fetch_count, 32'd3);
    tick();
    check("redir1.if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("redir1.if_pc", bus.if_pc, 32'h40);
    check("redir1.if_instr", bus.if_instr, mem[16]);
    tick();
    check("redir2.if_pc", bus.if_pc, 32'h44);
    check("redir2.fetch_count", bus.fetch_count, 32'd4);

    // Misaligned redirect faults; later redirects are ignored; reset clears it
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    bus.redirect_pc    = 32'h0;
    check("mis.fetch_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("mis.if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("mis.fetch_count", bus.fetch_count, 32'd5);
    check("mis.imem_addr", bus.imem_addr, 32'h42);
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_ign.fetch_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("mis_ign.imem_addr", bus.imem_addr, 32'h42);
    check("mis_ign.if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("mis_ign.fetch_count", bus.fetch_count, 32'd5);
    rst_n = 1'b0;
    tick();
    check("mis_rst.fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Run off the end of memory: last word delivered, then fault
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd112;
    tick();
    bus.redirect_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.if_valid && bus.if_pc == 32'd124) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("end.last_word_seen", {31'd0, seen}, 32'd1);
    check("end.last_instr", bus.if_instr, mem[31]);
    check("end.fault_before", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    check("end.fetch_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("end.if_valid", {31'd0, bus.if_valid}, 32'd0);

    // Reset during a stall with a redirect pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    tick();
    check("pre_rst.if_valid", {31'd0, bus.if_valid}, 32'd1);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    check_reset_values("stall_rst");
    bus.redirect_valid = 1'b0;
    rst_n              = 1'b1;
    bus.id_ready       = 1'b1;
    tick();

    // Randomized run against a stream-level scoreboard
    exp_addr    = 32'd0;
    count_m     = 32'd0;
    bubble_left = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd.if_valid", {31'd0, bus.if_valid}, {31'd0, (bubble_left == 0)});
      check("rnd.fetch_count", bus.fetch_count, count_m);
      check("rnd.fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
      if (bubble_left == 0) begin
        check("rnd.if_pc", bus.if_pc, exp_addr);
        check("rnd.if_instr", bus.if_instr, mem[exp_addr[6:2]]);
        check("rnd.if_pc_plus4", bus.if_pc_plus4, exp_addr + 32'd4);
      end else begin
        check("rnd.bubble_addr", bus.imem_addr, exp_addr);
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 7) == 0) || (bubble_left == 0 && exp_addr >= 32'd100);
      tgt   = 32'($urandom_range(0, 24)) * 32'd4;
      bus.id_ready       = rdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      if (bubble_left == 0 && rdy) begin
        count_m  = count_m + 32'd1;
        exp_addr = exp_addr + 32'd4;
      end
      if (redir) begin
        exp_addr    = tgt;
        bubble_left = 1;
      end else if (bubble_left > 0) begin
        bubble_left = bubble_left - 1;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    check("rnd.progress", {31'd0, (count_m > 32'd100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
